// File: rtl/memory_io_responder.sv
// Word-organised, byte-maskable RAM that answers memory_io_req with memory_io_rsp.
// Latency: response valid LATENCY+1 cycles after the accepting edge (one request in flight).
// Backpressure: ready is high only in IDLE; requests seen while ready=0 are ignored, not queued.

package memory_io_pkg;

    // Request from the core: one word-aligned access with per-lane masks.
    typedef struct packed {
        logic [31:0] addr;
        logic        valid;
        logic [3:0]  do_read;
        logic [3:0]  do_write;
        logic [31:0] data;
    } memory_io_req;

    // Response to the core: ready throttles new requests, valid marks the reply.
    typedef struct packed {
        logic        ready;
        logic        valid;
        logic [31:0] data;
    } memory_io_rsp;

endpackage

module memory_io_responder
    import memory_io_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic         clk,
    input  logic         reset,
    input  memory_io_req req,
    output memory_io_rsp rsp,
    output logic         err
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     lat_cnt;

    logic           ready_int;
    logic           valid_int;
    logic           accept;
    logic           req_in_range;

    // Latched copy of the accepted request; later changes on req are ignored.
    logic [AW-1:0]  l_idx;
    logic           l_in_range;
    logic [3:0]     l_rmask;
    logic [3:0]     l_wmask;
    logic [31:0]    l_wdata;

    logic [31:0]    mem [DEPTH];
    logic [31:0]    rd_word;
    logic [31:0]    resp_data;
    logic [31:0]    data_hold;
    logic           wr_en;

    // The core pre-aligns lanes, so the byte offset inside a word carries no information.
    logic           unused_addr_lsbs;
    assign unused_addr_lsbs = ^req.addr[1:0];

    assign ready_int    = (state == IDLE) && !reset;
    assign valid_int    = (state == RESP) && !reset;
    assign accept       = req.valid && ready_int;
    assign req_in_range = req.addr < LIMIT;

    // State register; reset drops any request in flight without a response.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: IDLE -> (WAIT for LATENCY cycles) -> RESP for one cycle -> IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (LAT == 4'd0) state_nxt = RESP;
                    else             state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == LAT) state_nxt = RESP;
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: handshake flags from state, data held between responses.
    always_comb begin
        rsp       = '0;
        rsp.ready = ready_int;
        rsp.valid = valid_int;
        rsp.data  = valid_int ? resp_data : data_hold;
    end

    // Wait counter runs 1..LATENCY while in WAIT and rests at zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt <= 4'd0;
        end else if (accept) begin
            lat_cnt <= 4'd1;
        end else if (state == WAIT && lat_cnt != LAT) begin
            lat_cnt <= lat_cnt + 4'd1;
        end else begin
            lat_cnt <= 4'd0;
        end
    end

    // Capture the request at acceptance so the requester may move on.
    always_ff @(posedge clk) begin
        if (accept) begin
            l_idx      <= req.addr[AW+1:2];
            l_in_range <= req_in_range;
            l_rmask    <= req.do_read;
            l_wmask    <= req.do_write;
            l_wdata    <= req.data;
        end
    end

    // Sticky error: any accepted out-of-range access, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept && !req_in_range) begin
            err <= 1'b1;
        end
    end

    // Response word: pre-write contents on stores, lane-masked contents on loads.
    always_comb begin
        rd_word   = l_in_range ? mem[l_idx] : 32'h0;
        resp_data = 32'h0;
        if (l_in_range) begin
            if (|l_wmask) begin
                resp_data = rd_word;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (l_rmask[b]) resp_data[8*b +: 8] = rd_word[8*b +: 8];
                end
            end
        end
    end

    // Stores commit on the response edge; out-of-range stores and aborted requests are dropped.
    assign wr_en = valid_int && l_in_range && (|l_wmask);

    // Byte-lane RAM write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (l_wmask[b]) mem[l_idx][8*b +: 8] <= l_wdata[8*b +: 8];
            end
        end
    end

    // Keep the last response data visible outside RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_hold <= 32'h0;
        end else if (valid_int) begin
            data_hold <= resp_data;
        end
    end

endmodule

// File: tb/tb_memory_io_responder.sv
// Self-checking bench: three responders (LATENCY 1, 0, 15) against a word-array reference model.
// Each access checks handshake timing cycle by cycle, response data and the sticky error flag.
// Random junk requests are pulsed while busy to confirm they are neither accepted nor queued.

module tb_memory_io_responder;
  import memory_io_pkg::*;

  localparam int DEPTH = 64;
  localparam int NI    = 3;

  logic         clk;
  logic         rst [NI];
  memory_io_req req [NI];
  memory_io_rsp rsp [NI];
  logic         err [NI];

  // Reference model: word array, knowledge flags and sticky error per instance.
  bit [31:0] mdl   [NI][DEPTH];
  bit        known [NI][DEPTH];
  bit        merr  [NI];

  int n_checks = 0;
  int n_fail   = 0;

  memory_io_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(rst[0]), .req(req[0]), .rsp(rsp[0]), .err(err[0]));
  memory_io_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(rst[1]), .req(req[1]), .rsp(rsp[1]), .err(err[1]));
  memory_io_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_lat15 (
    .clk(clk), .reset(rst[2]), .req(req[2]), .rsp(rsp[2]), .err(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access: drive at a negedge, then sample every negedge until the responder is idle again.
  task automatic txn(input int k, input logic [31:0] addr, input logic [3:0] rm,
                     input logic [3:0] wm, input logic [31:0] wd, input bit pulse);
    logic [31:0] exp;
    bit          inr;
    bit          chk_data;
    int          idx;
    int          lat;
    lat      = lat_of(k);
    inr      = addr < 32'(DEPTH * 4);
    idx      = int'(addr >> 2) % DEPTH;
    exp      = 32'h0;
    chk_data = 1'b1;
    if (!inr) begin
      merr[k] = 1'b1;
    end else if (wm != 4'h0) begin
      exp      = mdl[k][idx];
      chk_data = known[k][idx];
      for (int b = 0; b < 4; b++)
        if (wm[b]) mdl[k][idx][8*b +: 8] = wd[8*b +: 8];
      if (wm == 4'hF) known[k][idx] = 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (rm[b]) exp[8*b +: 8] = mdl[k][idx][8*b +: 8];
      chk_data = known[k][idx] || (rm == 4'h0);
    end

    req[k] = '{addr: addr, valid: 1'b1, do_read: rm, do_write: wm, data: wd};
    check($sformatf("k%0d ready_before_accept", k), 32'(rsp[k].ready), 32'd1);
    @(posedge clk);
    for (int j = 0; j <= lat + 1; j++) begin
      @(negedge clk);
      check($sformatf("k%0d valid_cyc%0d", k, j), 32'(rsp[k].valid), 32'(j == lat));
      check($sformatf("k%0d ready_cyc%0d", k, j), 32'(rsp[k].ready), 32'(j == lat + 1));
      if (j == lat && chk_data)
        check($sformatf("k%0d data @%h", k, addr), rsp[k].data, exp);
      if (j == lat + 1)
        check($sformatf("k%0d err", k), 32'(err[k]), 32'(merr[k]));
      req[k].addr     = $urandom;
      req[k].do_read  = 4'($urandom);
      req[k].do_write = 4'($urandom);
      req[k].data     = $urandom;
      req[k].valid    = (pulse && j <= lat) ? 1'($urandom) : 1'b0;
    end
  endtask

  // Abort a write while it waits; it must never answer nor modify memory.
  task automatic reset_abort(input int k, input int idx);
    req[k] = '{addr: 32'(idx * 4), valid: 1'b1, do_read: 4'hF, do_write: 4'hF,
               data: ~mdl[k][idx]};
    @(posedge clk);
    @(negedge clk);
    check($sformatf("k%0d abort_wait_valid", k), 32'(rsp[k].valid), 32'd0);
    req[k].valid = 1'b0;
    rst[k] = 1'b1;
    check($sformatf("k%0d abort_rst_ready", k), 32'(rsp[k].ready), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check($sformatf("k%0d in_rst_ready", k), 32'(rsp[k].ready), 32'd0);
      check($sformatf("k%0d in_rst_valid", k), 32'(rsp[k].valid), 32'd0);
    end
    rst[k]  = 1'b0;
    merr[k] = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check($sformatf("k%0d post_abort_valid", k), 32'(rsp[k].valid), 32'd0);
      check($sformatf("k%0d post_abort_ready", k), 32'(rsp[k].ready), 32'd1);
      check($sformatf("k%0d post_abort_err", k), 32'(err[k]), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  rm;
    logic [3:0]  wm;
    int          k;

    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1;
      req[i] = '0;
      merr[i] = 1'b0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("k%0d rst_ready", i), 32'(rsp[i].ready), 32'd0);
      check($sformatf("k%0d rst_valid", i), 32'(rsp[i].valid), 32'd0);
      check($sformatf("k%0d rst_data", i), rsp[i].data, 32'd0);
      check($sformatf("k%0d rst_err", i), 32'(err[i]), 32'd0);
      rst[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("k%0d ready_after_rst", i), 32'(rsp[i].ready), 32'd1);
      check($sformatf("k%0d valid_after_rst", i), 32'(rsp[i].valid), 32'd0);
    end

    // Fill every word with known random contents.
    for (int i = 0; i < NI; i++)
      for (int w = 0; w < DEPTH; w++)
        txn(i, 32'(w * 4), 4'h0, 4'hF, $urandom, 1'b0);

    // Directed read timing, lane merge and lane-masked read.
    txn(0, 32'h0, 4'hF, 4'h0, 32'h0, 1'b0);
    txn(0, 32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    txn(0, 32'h10, 4'h0, 4'b0001, 32'h000000AA, 1'b0);
    txn(0, 32'h10, 4'hF, 4'h0, 32'h0, 1'b0);
    txn(0, 32'h10, 4'b1100, 4'h0, 32'h0, 1'b0);
    txn(0, 32'h10, 4'h0, 4'h0, 32'h0, 1'b0);

    // Busy-time junk on the short and long latency builds.
    txn(1, 32'h20, 4'hF, 4'h0, 32'h0, 1'b1);
    txn(2, 32'h20, 4'hF, 4'h0, 32'h0, 1'b1);

    // Out-of-range write: zero data, sticky error, word 0 untouched.
    for (int i = 0; i < NI; i++) begin
      txn(i, 32'(DEPTH * 4), 4'h0, 4'hF, 32'h12345678, 1'b0);
      txn(i, 32'h0, 4'hF, 4'h0, 32'h0, 1'b0);
      txn(i, 32'h4, 4'h0, 4'b0110, $urandom, 1'b0);
    end

    // Reset in WAIT aborts the request and clears the error, memory survives.
    reset_abort(0, 5);
    txn(0, 32'h14, 4'hF, 4'h0, 32'h0, 1'b0);
    txn(0, 32'h10, 4'hF, 4'h0, 32'h0, 1'b0);
    reset_abort(2, 9);
    txn(2, 32'h24, 4'hF, 4'h0, 32'h0, 1'b0);

    // Randomised traffic across all three builds.
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, NI - 1);
      if ($urandom_range(0, 19) == 0)
        a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000));
      else
        a = 32'($urandom_range(0, DEPTH * 4 - 1));
      rm = 4'($urandom);
      wm = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      txn(k, a, rm, wm, $urandom, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
